// File: rtl/uart_pkg.sv
// Shared UART types, legal parameter ranges and symbol timing helper.
// Used by the framed receiver and the future transmitter loopback.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;
    localparam int MIN_CYCLES_PER_SYMBOL = 4;

    function automatic int cycles_per_symbol(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle level (1).
// Latency 2 cycles, no backpressure.
module uart_rx_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
        end
    end

    assign rx_s = sync_q;

endmodule

// File: rtl/uart_receiver_framed.sv
// Framed UART receiver: configurable data/stop bits, optional parity via UART_RECEIVER_PARITY_EN.
// Strobe one cycle after the last stop sample (2-3 cycles sync delay from the pin).
// No backpressure: every frame, errored or not, is delivered on byte_ready.
module uart_receiver_framed
    import uart_pkg::*;
#(
    parameter int clock_frequency = 50000000,
    parameter int baud_rate       = 115200,
    parameter int data_bits       = 8,
    parameter int stop_bits       = 1,
    parameter int parity_odd      = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [data_bits-1:0] byte_data,
    output logic                 byte_ready,
    output logic                 frame_error,
    output logic                 parity_error
);

    localparam int C     = cycles_per_symbol(clock_frequency, baud_rate);
    localparam int CNT_W = $clog2(C);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(C / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(C - 1);
    localparam logic [3:0] LAST_DATA = 4'(data_bits - 1);
    localparam logic [3:0] LAST_STOP = 4'(stop_bits - 1);

    if (C < MIN_CYCLES_PER_SYMBOL) begin : g_bad_baud
        $error("uart_receiver_framed: fewer than 4 clock cycles per symbol");
    end
    if (data_bits < DATA_BITS_MIN || data_bits > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_receiver_framed: data_bits out of range");
    end
    if (stop_bits < STOP_BITS_MIN || stop_bits > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_receiver_framed: stop_bits out of range");
    end
    if (parity_odd != 0 && parity_odd != 1) begin : g_bad_parity_sel
        $error("uart_receiver_framed: parity_odd must be 0 or 1");
    end

    logic rx_s;

    uart_rx_sync u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_s    (rx_s)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [data_bits-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 par_err_q, par_err_d;
    logic [data_bits-1:0] byte_data_q, byte_data_d;
    logic                 byte_ready_q, byte_ready_d;
    logic                 frame_error_q, frame_error_d;
    logic                 parity_error_q, parity_error_d;
    logic                 tick;

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        frame_err_d    = frame_err_q;
        par_err_d      = par_err_q;
        byte_data_d    = byte_data_q;
        byte_ready_d   = 1'b0;
        frame_error_d  = 1'b0;
        parity_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d       = FULL_LOAD;
                    bit_cnt_d   = '0;
                    frame_err_d = 1'b0;
                    par_err_d   = 1'b0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                    shift_d = {rx_s, shift_q[data_bits-1:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_RECEIVER_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RECEIVER_PARITY_EN
            ST_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_err_d = ((^shift_q) ^ rx_s) != 1'(parity_odd);
                    cnt_d     = FULL_LOAD;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    frame_err_d = frame_err_q | ~rx_s;
                    cnt_d       = FULL_LOAD;
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d      = '0;
                        byte_data_d    = shift_q;
                        byte_ready_d   = 1'b1;
                        frame_error_d  = frame_err_q | ~rx_s;
                        parity_error_d = par_err_q;
                        // A low final stop sample means the line is held low (break).
                        state_d        = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            frame_err_q    <= 1'b0;
            par_err_q      <= 1'b0;
            byte_data_q    <= '0;
            byte_ready_q   <= 1'b0;
            frame_error_q  <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            frame_err_q    <= frame_err_d;
            par_err_q      <= par_err_d;
            byte_data_q    <= byte_data_d;
            byte_ready_q   <= byte_ready_d;
            frame_error_q  <= frame_error_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign byte_data    = byte_data_q;
    assign byte_ready   = byte_ready_q;
    assign frame_error  = frame_error_q;
`ifdef UART_RECEIVER_PARITY_EN
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver_framed.sv
// Bench for uart_receiver_framed: 8N1 instance (a) and 7-data/2-stop instance (b), C = 50.
module tb_uart_receiver_framed;
    import uart_pkg::*;

    localparam int C = 50;
`ifdef UART_RECEIVER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Pin edge to strobe: 2 sync cycles + C/2 + (8 data + P + 1 stop) symbols + 1.
    localparam int LAT_A = 2 + C / 2 + (8 + P + 1) * C + 1;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_a    = 1'b1;
    logic       rx_b    = 1'b1;
    logic [7:0] data_a;
    logic       rdy_a, fe_a, pe_a;
    logic [6:0] data_b;
    logic       rdy_b, fe_b, pe_b;

    always #5 clock = ~clock;

    uart_receiver_framed #(
        .clock_frequency (500),
        .baud_rate       (10),
        .data_bits       (8),
        .stop_bits       (1),
        .parity_odd      (0)
    ) dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx           (rx_a),
        .byte_data    (data_a),
        .byte_ready   (rdy_a),
        .frame_error  (fe_a),
        .parity_error (pe_a)
    );

    uart_receiver_framed #(
        .clock_frequency (500),
        .baud_rate       (10),
        .data_bits       (7),
        .stop_bits       (2),
        .parity_odd      (0)
    ) dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx           (rx_b),
        .byte_data    (data_b),
        .byte_ready   (rdy_b),
        .frame_error  (fe_b),
        .parity_error (pe_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int stray = 0;

    typedef struct {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        int         cyc;
    } strobe_t;

    strobe_t q_a[$];
    strobe_t q_b[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rdy_a) q_a.push_back('{{1'b0, data_a}, fe_a, pe_a, cyc});
        else if (fe_a || pe_a) stray = stray + 1;
        if (rdy_b) q_b.push_back('{{2'b00, data_b}, fe_b, pe_b, cyc});
        else if (fe_b || pe_b) stray = stray + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input int ncyc);
        if (sel == 0) rx_a = v;
        else rx_b = v;
        repeat (ncyc) @(negedge clock);
    endtask

    // par_bit < 0 sends the correct even parity bit (only when parity is compiled in).
    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                              input int nstop, input logic stop_val, input int par_bit);
        logic p;
        p = 1'b0;
        drive(sel, 1'b0, C);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, d[i], C);
            p = p ^ d[i];
        end
`ifdef UART_RECEIVER_PARITY_EN
        drive(sel, (par_bit < 0) ? p : par_bit[0], C);
`else
        if (par_bit > 1) p = ~p;
`endif
        for (int i = 0; i < nstop; i++) drive(sel, stop_val, C);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int start_cyc;
        logic [7:0] exp_b;

        vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'hA3, 1'b0, 8'hA3, 1'b1};
        vecs[4] = '{8'h3C, 1'b1, 8'h3C, 1'b0};

        repeat (3) @(negedge clock);
        check("reset_byte_data", 32'(data_a), 32'h0);
        check("reset_byte_ready", 32'(rdy_a), 32'h0);
        check("reset_frame_error", 32'(fe_a), 32'h0);
        check("reset_parity_error", 32'(pe_a), 32'h0);
        check("reset_state", 32'(dut_a.state_q), 32'(ST_IDLE));
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            q_a.delete();
            start_cyc = cyc;
            send_frame(0, {1'b0, vecs[v].data}, 8, 1, vecs[v].stop_val, -1);
            if (!vecs[v].stop_val) drive(0, 1'b0, 200);
            drive(0, 1'b1, 2 * C);
            check($sformatf("vec%0d_strobes", v), 32'(q_a.size()), 32'd1);
            if (q_a.size() >= 1) begin
                check($sformatf("vec%0d_data", v), 32'(q_a[0].data), 32'(vecs[v].exp_data));
                check($sformatf("vec%0d_frame_error", v), 32'(q_a[0].fe), 32'(vecs[v].exp_fe));
                check($sformatf("vec%0d_parity_error", v), 32'(q_a[0].pe), 32'h0);
                if (v == 0) check("vec0_latency", 32'(q_a[0].cyc - start_cyc), 32'(LAT_A));
            end
        end
        check("byte_data_holds", 32'(data_a), 32'h3C);

        // Glitches shorter than half a symbol.
        q_a.delete();
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 3 * C);
        drive(0, 1'b0, 24);
        drive(0, 1'b1, 3 * C);
        check("glitch_no_strobe", 32'(q_a.size()), 32'd0);
        check("glitch_state_idle", 32'(dut_a.state_q), 32'(ST_IDLE));

`ifdef UART_RECEIVER_PARITY_EN
        q_a.delete();
        send_frame(0, 9'h001, 8, 1, 1'b1, 0);
        drive(0, 1'b1, 2 * C);
        send_frame(0, 9'h001, 8, 1, 1'b1, 1);
        drive(0, 1'b1, 2 * C);
        check("parity_strobes", 32'(q_a.size()), 32'd2);
        if (q_a.size() == 2) begin
            check("parity_bad_flag", 32'(q_a[0].pe), 32'h1);
            check("parity_good_flag", 32'(q_a[1].pe), 32'h0);
            check("parity_data", 32'(q_a[1].data), 32'h01);
        end
`endif

        // Ten back-to-back 7-bit, 2-stop frames.
        q_b.delete();
        for (int i = 0; i < 10; i++) begin
            exp_b = (i % 2 == 1) ? 8'h2A : 8'h55;
            send_frame(1, {1'b0, exp_b}, 7, 2, 1'b1, -1);
        end
        drive(1, 1'b1, 2 * C);
        check("b2b_strobes", 32'(q_b.size()), 32'd10);
        for (int i = 0; i < 10 && i < q_b.size(); i++) begin
            exp_b = (i % 2 == 1) ? 8'h2A : 8'h55;
            check($sformatf("b2b%0d_data", i), 32'(q_b[i].data), 32'(exp_b));
            check($sformatf("b2b%0d_errors", i), 32'({q_b[i].fe, q_b[i].pe}), 32'h0);
        end

        // Reset during data bit 4 of a frame, then a clean frame.
        q_a.delete();
        drive(0, 1'b0, C);
        drive(0, 1'b1, 4 * C + C / 2);
        reset_n = 1'b0;
        @(negedge clock);
        check("midreset_ready_low", 32'(rdy_a), 32'h0);
        check("midreset_state_idle", 32'(dut_a.state_q), 32'(ST_IDLE));
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        drive(0, 1'b1, 12 * C);
        check("midreset_no_strobe", 32'(q_a.size()), 32'd0);
        send_frame(0, 9'h00F, 8, 1, 1'b1, -1);
        drive(0, 1'b1, 2 * C);
        check("after_reset_strobes", 32'(q_a.size()), 32'd1);
        if (q_a.size() >= 1) begin
            check("after_reset_data", 32'(q_a[0].data), 32'h0F);
            check("after_reset_errors", 32'({q_a[0].fe, q_a[0].pe}), 32'h0);
        end

        check("flags_low_outside_strobe", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_receiver_framed.md
# uart_receiver_framed

Parametrised successor to the fixed 8N1 UART receiver. Receives asynchronous serial frames on `rx` with configurable data width, stop-bit count and optional parity. Samples each bit at mid-symbol after a validated start bit, and reports every completed frame with a one-cycle strobe plus framing and parity error flags. Sits between the board `rx` pin and byte consumers such as display and command decoders.

## Interface
- `clock_frequency`, 50000000: clock frequency in Hz.
- `baud_rate`, 115200: symbol rate in baud.
- `data_bits`, 8: data bits per frame, legal range 5..9.
- `stop_bits`, 1: stop bits per frame, 1 or 2.
- `parity_odd`, 0: 1 selects odd parity, 0 selects even. Only used when parity is compiled in.
- Derived value `clock_cycles_in_symbol` = clock_frequency / baud_rate (integer division). It must be at least 4; elaboration fails otherwise.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input, asynchronous, idles high.
- `byte_data`  out  data_bits  last received data word, LSB first on the wire.
- `byte_ready`  out  1  one-cycle strobe: a frame has completed.
- `frame_error`  out  1  valid only with `byte_ready`: a stop bit was sampled 0.
- `parity_error`  out  1  valid only with `byte_ready`: parity mismatch.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- In reset, all outputs are 0, state is IDLE and the counters are 0.
- States: IDLE, START, DATA, PARITY (only when compiled in), STOP, WAIT_HIGH.
- IDLE: when `rx_s`=0, load the counter with C/2−1 and go to START.
- START: on counter expiry, sample `rx_s`.
  - 1 means a glitch: return to IDLE with no output.
  - 0 means a valid start: load C−1 and go to DATA.
- DATA: on each expiry, shift `rx_s` in at the MSB of the shift register, so the word ends up LSB first. Reload C−1. After `data_bits` samples, go to PARITY, or to STOP if parity is not compiled in.
- PARITY: one sample. Error if the XOR of the data bits and the parity bit is not equal to `parity_odd`. Then go to STOP.
- STOP: take `stop_bits` samples. Any 0 sample sets the sticky frame flag. On the last sample:
  - register `byte_data`, `frame_error` and `parity_error`;
  - pulse `byte_ready`;
  - go to IDLE if the last stop sample was 1, otherwise go to WAIT_HIGH.
- WAIT_HIGH (break/line-low condition): stay until `rx_s`=1, then go to IDLE. No start bit is detected while in this state.
- A frame with errors is still delivered: `byte_data` is updated and `byte_ready` pulses. The consumer qualifies the data with the error flags.
- `byte_data` holds its value between strobes. `frame_error` and `parity_error` are 0 whenever `byte_ready` is 0.

## Timing
- C = `clock_cycles_in_symbol`. t0 = the first cycle with `rx_s`=0 in IDLE. t0 trails the pin edge by 2–3 cycles.
- Start sample at t0 + C/2. Data bit k (0-based) sampled at t0 + C/2 + (k+1)·C.
- P = 1 if parity is compiled in, else 0.
- Last stop sample at t0 + C/2 + (data_bits+P+stop_bits)·C. `byte_ready` is high on the next cycle, for exactly one cycle.
- Back-to-back frames: a start bit that begins immediately after the last stop bit is accepted. IDLE is re-entered half a symbol before the next start edge.
- A low-going glitch on `rx` shorter than C/2 cycles produces no strobe.
- Reset asserted mid-frame: `byte_ready` drops immediately and the partial frame is discarded. After release, the block waits in IDLE. If `rx` is held low at release, that low is treated as a new start.

## Configuration
- Macro `UART_RECEIVER_PARITY_EN`.
- Defined: the PARITY state exists, the frame carries one parity bit, and `parity_error` is computed as described above.
- Undefined: no PARITY state, `parity_error` is tied to 0, `parity_odd` is ignored, and the frame is start + data + stop.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum;
  - the `data_bits` and `stop_bits` legal-range constants;
  - a function computing cycles per symbol.
- Sub-module `uart_rx_sync` is the 2-flop synchronizer with a reset value of 1. It is reused by the future transmitter loopback.

## Test plan
All scenarios use clock_frequency=500, baud_rate=10 (C=50), data_bits=8, stop_bits=1 unless stated otherwise.
- Send frame 0x55 → exactly one `byte_ready`, `byte_data`=0x55, both error flags 0. The strobe lands 476 cycles after the first low `rx_s` cycle (t0 + 25 + 9·50 + 1).
- Drive `rx` low for 10 cycles, then high → no `byte_ready` and state returns to IDLE.
- Send 0xA3 with the stop bit 0, then hold `rx` low for 200 cycles, then send 0x3C → first strobe has `byte_data`=0xA3 and `frame_error`=1. No strobe while `rx` is low. Second strobe has 0x3C and no errors.
- With the macro defined and even parity, send 0x01 with parity bit 0 → `parity_error`=1. Send 0x01 with parity bit 1 → `parity_error`=0.
- With data_bits=7 and stop_bits=2, send ten back-to-back frames alternating 0x55 and 0x2A → ten strobes with the correct data and no errors.
- Assert `reset_n` during data bit 4, release it, then send 0x0F → no strobe for the aborted frame, and one strobe with 0x0F.
